alu_op_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_cmd_fifo.sv | 42 ++++
 rtl/alu_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and width defaults for the ALU command sequencer.
package alu_pkg;

    localparam int unsigned WIDTH_D = 32;
    localparam int unsigned OPW_D   = 4;
    localparam int unsigned SHW_D   = 5;
    localparam int unsigned TAGW_D  = 4;
    localparam int unsigned DEPTH_D = 4;

    localparam logic [OPW_D-1:0] OP_ADD  = 4'd0;
    localparam logic [OPW_D-1:0] OP_SUB  = 4'd1;
    localparam logic [OPW_D-1:0] OP_AND  = 4'd2;
    localparam logic [OPW_D-1:0] OP_OR   = 4'd3;
    localparam logic [OPW_D-1:0] OP_SLL  = 4'd4;
    localparam logic [OPW_D-1:0] OP_XOR  = 4'd5;
    localparam logic [OPW_D-1:0] OP_SLTU = 4'd6;
    localparam logic [OPW_D-1:0] OP_MIN  = 4'd7;
    localparam logic [OPW_D-1:0] OP_NOR  = 4'd8;
    localparam logic [OPW_D-1:0] OP_SRL  = 4'd9;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    // SLTU is left undriven by the ALU, so it is never issued.
    function automatic logic is_illegal_op(input logic [OPW_D-1:0] op);
        return (op == OP_SLTU) || (op > OP_SRL);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: power-of-two depth, extra pointer MSB distinguishes full from empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = DEPTH_D
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues tagged ALU requests, drives the ALU from registers and returns tagged responses.
// Optional feature macro: ALU_SEQ_CARRY_EN (sequencer-computed carry flag).
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_D,
    parameter int unsigned OPW   = OPW_D,
    parameter int unsigned SHW   = SHW_D,
    parameter int unsigned TAGW  = TAGW_D,
    parameter int unsigned DEPTH = DEPTH_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPW-1:0]   cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SHW-1:0]   cmd_shamt,
    input  logic [TAGW-1:0]  cmd_tag,
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [SHW-1:0]   alu_shift,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_sign,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_sign,
    output logic             rsp_carry,
    output logic             rsp_illegal,
    output logic [TAGW-1:0]  rsp_tag
);

    localparam int unsigned DW = OPW + 2*WIDTH + SHW + TAGW;

    state_t          state;
    logic            run_q;
    logic            full, empty, push, load;
    logic [DW-1:0]   head;
    logic [OPW-1:0]  head_op;
    logic [WIDTH-1:0] head_a, head_b;
    logic [SHW-1:0]  head_sh;
    logic [TAGW-1:0] head_tag;
    logic            head_ill;
    logic [TAGW-1:0] pend_tag;
    logic            pend_ill;

    assign cmd_ready = run_q & ~full;
    assign push      = cmd_valid & cmd_ready;
    assign load      = ~empty & ((state == IDLE) | ((state == RESP) & rsp_ready));
    assign {head_op, head_a, head_b, head_sh, head_tag} = head;
    assign head_ill  = is_illegal_op(head_op);

    alu_cmd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({cmd_opcode, cmd_a, cmd_b, cmd_shamt, cmd_tag}),
        .pop   (load),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            run_q       <= 1'b0;
            alu_opcode  <= '0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_shift   <= '0;
            pend_tag    <= '0;
            pend_ill    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_sign    <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_tag     <= '0;
        end else begin
            run_q <= 1'b1;
            // Illegal requests present an all-zero ADD so the ALU never sees them.
            if (load) begin
                alu_opcode <= head_ill ? '0 : head_op;
                alu_in1    <= head_ill ? '0 : head_a;
                alu_in2    <= head_ill ? '0 : head_b;
                alu_shift  <= head_ill ? '0 : head_sh;
                pend_tag   <= head_tag;
                pend_ill   <= head_ill;
            end
            case (state)
                IDLE: begin
                    if (load) state <= SETTLE;
                end
                SETTLE: begin
                    rsp_result  <= pend_ill ? '0 : alu_result;
                    rsp_zero    <= pend_ill | alu_zero;
                    rsp_sign    <= ~pend_ill & alu_sign;
                    rsp_illegal <= pend_ill;
                    rsp_tag     <= pend_tag;
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= load ? SETTLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_CARRY_EN
    logic [WIDTH:0] sum;
    logic           carry_d;

    assign sum = {1'b0, alu_in1} + {1'b0, alu_in2};

    always_comb begin
        carry_d = 1'b0;
        if (!pend_ill) begin
            if (alu_opcode == OP_ADD)      carry_d = sum[WIDTH];
            else if (alu_opcode == OP_SUB) carry_d = (alu_in1 < alu_in2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                  rsp_carry <= 1'b0;
        else if (state == SETTLE)    rsp_carry <= carry_d;
    end
`else
    assign rsp_carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_CARRY_EN
    localparam bit CARRY_ON = 1'b1;
`else
    localparam bit CARRY_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [31:0] cmd_a, cmd_b;
    logic [4:0]  cmd_shamt;
    logic [3:0]  cmd_tag;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_in1, alu_in2;
    logic [4:0]  alu_shift;
    logic [31:0] alu_result;
    logic        alu_zero, alu_sign;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_sign, rsp_carry, rsp_illegal;
    logic [3:0]  rsp_tag;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(32), .OPW(4), .SHW(5), .TAGW(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt), .cmd_tag(cmd_tag),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shift(alu_shift),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_carry(rsp_carry),
        .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag)
    );

    // Behavioural ALU; SLTU and unused codes return a marker value.
    always_comb begin
        case (alu_opcode)
            4'd0: alu_result = alu_in1 + alu_in2;
            4'd1: alu_result = alu_in1 - alu_in2;
            4'd2: alu_result = alu_in1 & alu_in2;
            4'd3: alu_result = alu_in1 | alu_in2;
            4'd4: alu_result = alu_in1 << alu_shift;
            4'd5: alu_result = alu_in1 ^ alu_in2;
            4'd7: alu_result = (alu_in1 < alu_in2) ? alu_in1 : alu_in2;
            4'd8: alu_result = ~(alu_in1 | alu_in2);
            4'd9: alu_result = alu_in1 >> alu_shift;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
        alu_sign = alu_result[31];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [3:0] tag);
        int n = 0;
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shamt = sh; cmd_tag = tag;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL push_timeout tag=%0d cmd_ready stayed %0b, required 1", tag, cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    // Pushes one command into an idle sequencer and records what is seen at each cycle.
    task automatic run_one(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [3:0] tag,
                           output logic v0, output logic v1, output logic [3:0] s_op,
                           output logic [31:0] s_in1, output logic [31:0] s_shres,
                           output logic v2, output logic [31:0] res, output logic z,
                           output logic s, output logic c, output logic ill,
                           output logic [3:0] t, output logic v_after);
        push(op, a, b, sh, tag);
        v0 = rsp_valid;
        step();
        v1 = rsp_valid; s_op = alu_opcode; s_in1 = alu_in1; s_shres = {27'd0, alu_shift};
        step();
        v2 = rsp_valid; res = rsp_result; z = rsp_zero; s = rsp_sign; c = rsp_carry;
        ill = rsp_illegal; t = rsp_tag;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        v_after = rsp_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_shamt = '0; cmd_tag = '0;
        step(); step();
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_handshake ready/valid=%b required 00", {cmd_ready, rsp_valid});
        end
        checks++;
        if ({rsp_result, rsp_zero, rsp_sign, rsp_carry, rsp_illegal, rsp_tag} !== 40'd0) begin
            failures++;
            $display("FAIL reset_rsp result=%h z=%b s=%b c=%b ill=%b tag=%h required all 0",
                     rsp_result, rsp_zero, rsp_sign, rsp_carry, rsp_illegal, rsp_tag);
        end
        checks++;
        if ({alu_opcode, alu_in1, alu_in2, alu_shift} !== 73'd0) begin
            failures++;
            $display("FAIL reset_alu op=%h in1=%h in2=%h sh=%h required 0",
                     alu_opcode, alu_in1, alu_in2, alu_shift);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_release got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_add_carry();
        logic v0, v1, v2, z, s, c, ill, va;
        logic [3:0] sop, t;
        logic [31:0] sin1, ssh, res;
        run_one(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd3, v0, v1, sop, sin1, ssh, v2, res, z, s, c, ill, t, va);
        checks++;
        if ({v0, v1, v2} !== 3'b001) begin
            failures++;
            $display("FAIL add_latency valid@N,N+1,N+2=%b required 001", {v0, v1, v2});
        end
        checks++;
        if (sop !== 4'd0 || sin1 !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL add_alu_drive op=%h in1=%h required 0/ffffffff", sop, sin1);
        end
        checks++;
        if (res !== 32'd0 || z !== 1'b1 || s !== 1'b0 || c !== CARRY_ON || ill !== 1'b0 || t !== 4'd3) begin
            failures++;
            $display("FAIL add_rsp res=%h z=%b s=%b c=%b ill=%b tag=%h required 0/1/0/%b/0/3",
                     res, z, s, c, ill, t, CARRY_ON);
        end
        checks++;
        if (va !== 1'b0) begin
            failures++;
            $display("FAIL add_drop_after_hs valid=%b required 0", va);
        end
    endtask

    task automatic test_sub_sll();
        logic v0, v1, v2, z, s, c, ill, va;
        logic [3:0] sop, t;
        logic [31:0] sin1, ssh, res;
        run_one(4'd1, 32'd5, 32'd7, 5'd0, 4'd5, v0, v1, sop, sin1, ssh, v2, res, z, s, c, ill, t, va);
        checks++;
        if (v2 !== 1'b1 || res !== 32'hFFFF_FFFE || z !== 1'b0 || s !== 1'b1 || c !== CARRY_ON || t !== 4'd5) begin
            failures++;
            $display("FAIL sub_rsp v=%b res=%h z=%b s=%b c=%b tag=%h required 1/fffffffe/0/1/%b/5",
                     v2, res, z, s, c, t, CARRY_ON);
        end
        run_one(4'd4, 32'd1, 32'h1234_5678, 5'd31, 4'd9, v0, v1, sop, sin1, ssh, v2, res, z, s, c, ill, t, va);
        checks++;
        if (ssh !== 32'd31 || res !== 32'h8000_0000 || s !== 1'b1 || c !== 1'b0 || ill !== 1'b0 || t !== 4'd9) begin
            failures++;
            $display("FAIL sll_rsp shift=%0d res=%h s=%b c=%b ill=%b tag=%h required 31/80000000/1/0/0/9",
                     ssh, res, s, c, ill, t);
        end
        run_one(4'd8, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 4'd1, v0, v1, sop, sin1, ssh, v2, res, z, s, c, ill, t, va);
        checks++;
        if (res !== 32'hF0F0_FF0F || t !== 4'd1 || ill !== 1'b0) begin
            failures++;
            $display("FAIL nor_rsp res=%h tag=%h ill=%b required f0f0ff0f/1/0", res, t, ill);
        end
    endtask

    task automatic test_illegal();
        logic v0, v1, v2, z, s, c, ill, va;
        logic [3:0] sop, t;
        logic [31:0] sin1, ssh, res;
        run_one(4'd6, 32'h0000_0003, 32'd9, 5'd4, 4'd6, v0, v1, sop, sin1, ssh, v2, res, z, s, c, ill, t, va);
        checks++;
        if (sop !== 4'd0 || sin1 !== 32'd0 || ssh !== 32'd0) begin
            failures++;
            $display("FAIL sltu_alu_drive op=%h in1=%h sh=%h required 0", sop, sin1, ssh);
        end
        checks++;
        if (ill !== 1'b1 || res !== 32'd0 || z !== 1'b1 || s !== 1'b0 || c !== 1'b0 || t !== 4'd6) begin
            failures++;
            $display("FAIL sltu_rsp ill=%b res=%h z=%b s=%b c=%b tag=%h required 1/0/1/0/0/6",
                     ill, res, z, s, c, t);
        end
        run_one(4'd12, 32'h8000_0001, 32'h8000_0001, 5'd1, 4'd12, v0, v1, sop, sin1, ssh, v2, res, z, s, c, ill, t, va);
        checks++;
        if (sop !== 4'd0 || ill !== 1'b1 || res !== 32'd0 || z !== 1'b1 || s !== 1'b0 || t !== 4'd12) begin
            failures++;
            $display("FAIL op12_rsp alu_op=%h ill=%b res=%h z=%b s=%b tag=%h required 0/1/0/1/0/c",
                     sop, ill, res, z, s, t);
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int stable_ok = 1;
        int tag_ok = 1;
        int gap_ok = 1;
        int last_cyc = 0;
        for (int i = 0; i < 5; i++) push(4'd0, 32'(i), 32'(i), 5'd0, 4'(i));
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_backpressure cmd_ready=%b required 0", cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'd0 || rsp_result !== 32'd0) stable_ok = 0;
            step();
        end
        checks++;
        if (stable_ok == 0) begin
            failures++;
            $display("FAIL hold_stable valid=%b tag=%h required 1/0 held", rsp_valid, rsp_tag);
        end
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
            if (rsp_valid === 1'b1) begin
                if (rsp_tag !== 4'(got) || rsp_result !== 32'(2 * got)) tag_ok = 0;
                if (got > 0 && cyc - last_cyc != 2) gap_ok = 0;
                last_cyc = cyc;
                got++;
            end
            step();
        end
        rsp_ready = 1'b0;
        checks++;
        if (got != 5 || tag_ok == 0) begin
            failures++;
            $display("FAIL order responses=%0d in_order=%0d required 5/1", got, tag_ok);
        end
        checks++;
        if (gap_ok == 0) begin
            failures++;
            $display("FAIL throughput gap_ok=%0d required one response per 2 cycles", gap_ok);
        end
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL drained ready=%b valid=%b required 1/0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_midflight();
        int n = 0;
        int stale = 0;
        push(4'd3, 32'h1, 32'h2, 5'd0, 4'd7);
        push(4'd5, 32'h3, 32'h4, 5'd0, 4'd8);
        push(4'd9, 32'h80, 32'h0, 5'd3, 4'd9);
        while (rsp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd7 || rsp_result !== 32'd3) begin
            failures++;
            $display("FAIL pre_reset_rsp valid=%b tag=%h res=%h required 1/7/3", rsp_valid, rsp_tag, rsp_result);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || {alu_opcode, alu_in1, alu_in2, alu_shift} !== 73'd0) begin
            failures++;
            $display("FAIL midreset valid=%b ready=%b op=%h in1=%h in2=%h sh=%h required 0",
                     rsp_valid, cmd_ready, alu_opcode, alu_in1, alu_in2, alu_shift);
        end
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid !== 1'b0) stale++;
        end
        rsp_ready = 1'b0;
        checks++;
        if (stale != 0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL stale_after_reset stale=%0d ready=%b required 0/1", stale, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub_sll();
        test_illegal();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
